// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and control-flow manager for the five-stage rv32 pipeline.
// Forwards operands into decode, stalls on load-use, flushes on taken branches/jumps.
module hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_de,
  input  logic [XLEN-1:0]  data_a_de,
  input  logic [XLEN-1:0]  data_b_de,
  input  logic [31:0]      instr_exe,
  input  logic [XLEN-1:0]  alu_out_exe,
  input  logic [XLEN-1:0]  pc_exe,
  input  logic [XLEN-1:0]  exe_a,
  input  logic [XLEN-1:0]  exe_b,
  input  logic [31:0]      instr_acc,
  input  logic [XLEN-1:0]  alu_out_acc,
  input  logic [XLEN-1:0]  dmem_out_acc,
  input  logic [XLEN-1:0]  pc_4_acc,
  input  logic [31:0]      instr_wb,
  input  logic [XLEN-1:0]  data_d_wb,
  output logic [XLEN-1:0]  data_a_mgr,
  output logic [XLEN-1:0]  data_b_mgr,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic             stall,
  output logic             pc_sel,
  output logic             false_path,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int MAXC = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] STALL_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LINK, WB_MEM} wb_e;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_e;

  // A single-cycle stall/flush is fully covered by the detecting cycle itself.
  localparam state_e STALL_NEXT = state_e'((LOAD_LAT > 1) ? ST_STALL : ST_RUN);
  localparam state_e FLUSH_NEXT = state_e'((FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN);

  function automatic wb_e wb_class(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_IMM, OP_REG: wb_class = WB_ALU;
      OP_JAL, OP_JALR:                  wb_class = WB_LINK;
      OP_LOAD:                          wb_class = WB_MEM;
      default:                          wb_class = WB_NONE;
    endcase
  endfunction

  function automatic logic rd_hit(input logic [4:0] rd, input wb_e cls, input logic [4:0] rs);
    rd_hit = (rd == rs) && (rd != 5'd0) && (cls != WB_NONE);
  endfunction

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  wb_e             cls_exe_s, cls_acc_s, cls_wb_s;
  logic [4:0]      rs1_s, rs2_s, rd_exe_s, rd_acc_s, rd_wb_s;
  logic [XLEN-1:0] exe_src_s, acc_src_s;
  logic            exe_a_hit_s, exe_b_hit_s, acc_a_hit_s, acc_b_hit_s, wb_a_hit_s, wb_b_hit_s;
  logic            load_use_s, br_cond_s, jump_s, redirect_s;
  logic            unused_s;

  assign rs1_s     = instr_de[19:15];
  assign rs2_s     = instr_de[24:20];
  assign rd_exe_s  = instr_exe[11:7];
  assign rd_acc_s  = instr_acc[11:7];
  assign rd_wb_s   = instr_wb[11:7];
  assign cls_exe_s = wb_class(instr_exe[6:0]);
  assign cls_acc_s = wb_class(instr_acc[6:0]);
  assign cls_wb_s  = wb_class(instr_wb[6:0]);
  assign unused_s  = ^{instr_de[31:25], instr_de[14:0], instr_exe[31:15],
                       instr_acc[31:12], instr_wb[31:12]};

  // A load still in EXE has no data yet: it never forwards, it stalls instead.
  assign exe_a_hit_s = rd_hit(rd_exe_s, cls_exe_s, rs1_s) && (cls_exe_s != WB_MEM);
  assign exe_b_hit_s = rd_hit(rd_exe_s, cls_exe_s, rs2_s) && (cls_exe_s != WB_MEM);
  assign acc_a_hit_s = rd_hit(rd_acc_s, cls_acc_s, rs1_s);
  assign acc_b_hit_s = rd_hit(rd_acc_s, cls_acc_s, rs2_s);
  assign wb_a_hit_s  = rd_hit(rd_wb_s, cls_wb_s, rs1_s);
  assign wb_b_hit_s  = rd_hit(rd_wb_s, cls_wb_s, rs2_s);
  assign load_use_s  = (cls_exe_s == WB_MEM) && (rd_exe_s != 5'd0) &&
                       ((rd_exe_s == rs1_s) || (rd_exe_s == rs2_s));

  assign exe_src_s = (cls_exe_s == WB_LINK) ? (pc_exe + XLEN'(4)) : alu_out_exe;

  always_comb begin
    case (cls_acc_s)
      WB_MEM:  acc_src_s = dmem_out_acc;
      WB_LINK: acc_src_s = pc_4_acc;
      default: acc_src_s = alu_out_acc;
    endcase
  end

  always_comb begin
    data_a_mgr = data_a_de;
    hazard_a   = 1'b0;
    if (exe_a_hit_s) begin
      data_a_mgr = exe_src_s;
      hazard_a   = 1'b1;
    end else if (acc_a_hit_s) begin
      data_a_mgr = acc_src_s;
      hazard_a   = 1'b1;
    end else if (wb_a_hit_s) begin
      data_a_mgr = data_d_wb;
      hazard_a   = 1'b1;
    end else begin
      data_a_mgr = data_a_de;
      hazard_a   = 1'b0;
    end
  end

  always_comb begin
    data_b_mgr = data_b_de;
    hazard_b   = 1'b0;
    if (exe_b_hit_s) begin
      data_b_mgr = exe_src_s;
      hazard_b   = 1'b1;
    end else if (acc_b_hit_s) begin
      data_b_mgr = acc_src_s;
      hazard_b   = 1'b1;
    end else if (wb_b_hit_s) begin
      data_b_mgr = data_d_wb;
      hazard_b   = 1'b1;
    end else begin
      data_b_mgr = data_b_de;
      hazard_b   = 1'b0;
    end
  end

  always_comb begin
    case (instr_exe[14:12])
      3'b000:  br_cond_s = (exe_a == exe_b);
      3'b001:  br_cond_s = (exe_a != exe_b);
      3'b100:  br_cond_s = ($signed(exe_a) < $signed(exe_b));
      3'b101:  br_cond_s = ($signed(exe_a) >= $signed(exe_b));
      3'b110:  br_cond_s = (exe_a < exe_b);
      3'b111:  br_cond_s = (exe_a >= exe_b);
      default: br_cond_s = 1'b0;
    endcase
  end

  // The EXE slot during FLUSH belongs to a killed instruction.
  assign jump_s     = (instr_exe[6:0] == OP_JAL) || (instr_exe[6:0] == OP_JALR);
  assign redirect_s = (state_q != ST_FLUSH) &&
                      (jump_s || ((instr_exe[6:0] == OP_BRANCH) && br_cond_s));
  assign pc_sel     = redirect_s;
  assign false_path = redirect_s || (state_q == ST_FLUSH);
  assign stall      = !redirect_s &&
                      ((state_q == ST_STALL) || ((state_q == ST_RUN) && load_use_s));

  // cnt_q holds the stall/flush cycles still to come after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= CW'(0);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect_s) begin
            state_q <= FLUSH_NEXT;
            cnt_q   <= FLUSH_INIT;
          end else if (load_use_s) begin
            state_q <= STALL_NEXT;
            cnt_q   <= STALL_INIT;
          end else begin
            state_q <= ST_RUN;
            cnt_q   <= CW'(0);
          end
        end
        ST_STALL: begin
          if (redirect_s) begin
            state_q <= FLUSH_NEXT;
            cnt_q   <= FLUSH_INIT;
          end else if (cnt_q > CW'(1)) begin
            state_q <= ST_STALL;
            cnt_q   <= cnt_q - CW'(1);
          end else begin
            state_q <= ST_RUN;
            cnt_q   <= CW'(0);
          end
        end
        ST_FLUSH: begin
          if (cnt_q > CW'(1)) begin
            state_q <= ST_FLUSH;
            cnt_q   <= cnt_q - CW'(1);
          end else begin
            state_q <= ST_RUN;
            cnt_q   <= CW'(0);
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= CW'(0);
        end
      endcase
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;
  assign flush_cnt_d = (pc_sel && (flush_cnt_q != {CNT_W{1'b1}})) ?
                       (flush_cnt_q + CNT_W'(1)) : flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= CNT_W'(0);
      flush_cnt_q <= CNT_W'(0);
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl; two instances with different
// latency/counter parameters are compared against a cycle-level reference model.
module tb_hazard_ctrl;

  logic        clk, rst;
  logic [31:0] instr_de, data_a_de, data_b_de, instr_exe, alu_out_exe, pc_exe, exe_a, exe_b;
  logic [31:0] instr_acc, alu_out_acc, dmem_out_acc, pc_4_acc, instr_wb, data_d_wb;

  logic [31:0] data_a_mgr, data_b_mgr, data_a_mgr2, data_b_mgr2;
  logic        hazard_a, hazard_b, stall, pc_sel, false_path;
  logic        hazard_a2, hazard_b2, stall2, pc_sel2, false_path2;
  logic [15:0] stall_count, flush_count;
  logic [3:0]  stall_count2, flush_count2;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] ADD_X5       = {7'd0, 5'd0, 5'd0, 3'd0, 5'd5, 7'b0110011};
  localparam logic [31:0] ADD_X0       = {7'd0, 5'd1, 5'd2, 3'd0, 5'd0, 7'b0110011};
  localparam logic [31:0] ADDI_X5      = {12'd0, 5'd0, 3'd0, 5'd5, 7'b0010011};
  localparam logic [31:0] ADD_X1_X5_X5 = {7'd0, 5'd5, 5'd5, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] ADD_X1_X0_X7 = {7'd0, 5'd7, 5'd0, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] ADD_X1_X0_X3 = {7'd0, 5'd3, 5'd0, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] LW_X7        = {12'd0, 5'd0, 3'b010, 5'd7, 7'b0000011};
  localparam logic [31:0] BLT          = {7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011};
  localparam logic [31:0] BLTU         = {7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011};
  localparam logic [31:0] BEQ          = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] JAL_X1       = {20'd0, 5'd1, 7'b1101111};

  hazard_ctrl #(.XLEN(32), .LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .instr_de(instr_de), .data_a_de(data_a_de), .data_b_de(data_b_de),
    .instr_exe(instr_exe), .alu_out_exe(alu_out_exe), .pc_exe(pc_exe), .exe_a(exe_a), .exe_b(exe_b),
    .instr_acc(instr_acc), .alu_out_acc(alu_out_acc), .dmem_out_acc(dmem_out_acc), .pc_4_acc(pc_4_acc),
    .instr_wb(instr_wb), .data_d_wb(data_d_wb), .data_a_mgr(data_a_mgr), .data_b_mgr(data_b_mgr),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .stall(stall), .pc_sel(pc_sel), .false_path(false_path),
    .stall_count(stall_count), .flush_count(flush_count));

  hazard_ctrl #(.XLEN(32), .LOAD_LAT(4), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .instr_de(instr_de), .data_a_de(data_a_de), .data_b_de(data_b_de),
    .instr_exe(instr_exe), .alu_out_exe(alu_out_exe), .pc_exe(pc_exe), .exe_a(exe_a), .exe_b(exe_b),
    .instr_acc(instr_acc), .alu_out_acc(alu_out_acc), .dmem_out_acc(dmem_out_acc), .pc_4_acc(pc_4_acc),
    .instr_wb(instr_wb), .data_d_wb(data_d_wb), .data_a_mgr(data_a_mgr2), .data_b_mgr(data_b_mgr2),
    .hazard_a(hazard_a2), .hazard_b(hazard_b2), .stall(stall2), .pc_sel(pc_sel2), .false_path(false_path2),
    .stall_count(stall_count2), .flush_count(flush_count2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: remaining stall / flush cycles and counters per instance.
  int ll[2]   = '{3, 4};
  int fc[2]   = '{2, 3};
  int cmax[2] = '{65535, 15};
  int stall_left[2], flush_left[2], scnt[2], fcnt[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  // 0 none, 1 alu, 2 link, 3 mem
  function automatic int wb_cls(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return 1;
      7'b1101111, 7'b1100111:                         return 2;
      7'b0000011:                                     return 3;
      default:                                        return 0;
    endcase
  endfunction

  function automatic bit writes(input logic [31:0] ins, input logic [4:0] rs);
    return (rs != 5'd0) && (ins[11:7] == rs) && (wb_cls(ins) != 0);
  endfunction

  task automatic ref_fwd(input logic [4:0] rs, input logic [31:0] dflt,
                         output logic [31:0] v, output logic hz);
    hz = 1'b1;
    if (writes(instr_exe, rs) && wb_cls(instr_exe) == 1)      v = alu_out_exe;
    else if (writes(instr_exe, rs) && wb_cls(instr_exe) == 2) v = pc_exe + 32'd4;
    else if (writes(instr_acc, rs))
      v = (wb_cls(instr_acc) == 1) ? alu_out_acc : (wb_cls(instr_acc) == 3) ? dmem_out_acc : pc_4_acc;
    else if (writes(instr_wb, rs))                            v = data_d_wb;
    else begin
      hz = 1'b0;
      v  = dflt;
    end
  endtask

  function automatic bit ref_taken();
    logic [6:0] op;
    op = instr_exe[6:0];
    if (op == 7'b1101111 || op == 7'b1100111) return 1'b1;
    if (op != 7'b1100011) return 1'b0;
    case (instr_exe[14:12])
      3'd0: return exe_a == exe_b;
      3'd1: return exe_a != exe_b;
      3'd4: return $signed(exe_a) < $signed(exe_b);
      3'd5: return $signed(exe_a) >= $signed(exe_b);
      3'd6: return exe_a < exe_b;
      3'd7: return exe_a >= exe_b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_load_use();
    return wb_cls(instr_exe) == 3 && instr_exe[11:7] != 5'd0 &&
           (instr_exe[11:7] == instr_de[19:15] || instr_exe[11:7] == instr_de[24:20]);
  endfunction

  task automatic ref_ctl(input int k, output logic st, output logic pc, output logic fp);
    bit flushing;
    flushing = flush_left[k] > 0;
    pc = !flushing && ref_taken();
    st = !pc && (stall_left[k] > 0 || (!flushing && ref_load_use()));
    fp = pc || flushing;
  endtask

  task automatic model_update();
    logic st, pc, fp;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        stall_left[k] = 0; flush_left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
        ref_ctl(k, st, pc, fp);
        if (st && scnt[k] < cmax[k]) scnt[k]++;
        if (pc && fcnt[k] < cmax[k]) fcnt[k]++;
        if (pc) begin
          flush_left[k] = fc[k] - 1;
          stall_left[k] = 0;
        end else if (flush_left[k] > 0) flush_left[k]--;
        else if (stall_left[k] > 0)     stall_left[k]--;
        else if (ref_load_use())        stall_left[k] = ll[k] - 1;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] va, vb;
    logic ha, hb, st, pc, fp;
    ref_fwd(instr_de[19:15], data_a_de, va, ha);
    ref_fwd(instr_de[24:20], data_b_de, vb, hb);
    check("data_a", data_a_mgr, va);
    check("data_b", data_b_mgr, vb);
    check("hazard_a", {31'd0, hazard_a}, {31'd0, ha});
    check("hazard_b", {31'd0, hazard_b}, {31'd0, hb});
    ref_ctl(0, st, pc, fp);
    check("stall", {31'd0, stall}, {31'd0, st});
    check("pc_sel", {31'd0, pc_sel}, {31'd0, pc});
    check("false_path", {31'd0, false_path}, {31'd0, fp});
    check("stall_count", {16'd0, stall_count}, scnt[0]);
    check("flush_count", {16'd0, flush_count}, fcnt[0]);
    ref_ctl(1, st, pc, fp);
    check("stall2", {31'd0, stall2}, {31'd0, st});
    check("pc_sel2", {31'd0, pc_sel2}, {31'd0, pc});
    check("false_path2", {31'd0, false_path2}, {31'd0, fp});
    check("stall_count2", {28'd0, stall_count2}, scnt[1]);
    check("flush_count2", {28'd0, flush_count2}, fcnt[1]);
    check("data_a2", data_a_mgr2, va);
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  logic [6:0] ops[12] = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0000011,
                          7'b0000011, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0100011, 7'b1110011};

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    op = ops[$urandom_range(0, 11)];
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  function automatic logic [31:0] rand_opnd();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
  endfunction

  task automatic set_nop();
    instr_de = NOP; instr_exe = NOP; instr_acc = NOP; instr_wb = NOP;
    data_a_de = $urandom; data_b_de = $urandom; alu_out_exe = $urandom; pc_exe = $urandom;
    exe_a = $urandom; exe_b = $urandom; alu_out_acc = $urandom; dmem_out_acc = $urandom;
    pc_4_acc = $urandom; data_d_wb = $urandom;
  endtask

  task automatic rand_inputs();
    set_nop();
    instr_de = rand_instr(); instr_exe = rand_instr(); instr_acc = rand_instr(); instr_wb = rand_instr();
    exe_a = rand_opnd(); exe_b = rand_opnd();
    if ($urandom_range(0, 7) == 0) pc_exe = 32'hFFFF_FFFC;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_nop();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_nop();
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; flush_left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fp", {31'd0, false_path}, 32'd0);
    check("rst_scnt", {16'd0, stall_count}, 32'd0);
    check("rst_fcnt", {16'd0, flush_count}, 32'd0);
    tick();

    // EXE beats ACC; killing EXE's rd exposes ACC
    set_nop();
    instr_exe = ADD_X5; alu_out_exe = 32'h11; instr_acc = ADDI_X5; alu_out_acc = 32'h22;
    instr_de = ADD_X1_X5_X5;
    #1;
    check("fwd_exe_a", data_a_mgr, 32'h11);
    check("fwd_exe_b", data_b_mgr, 32'h11);
    check("fwd_exe_ha", {31'd0, hazard_a}, 32'd1);
    check("fwd_exe_hb", {31'd0, hazard_b}, 32'd1);
    tick();
    instr_exe = ADD_X0;
    #1;
    check("fwd_acc_a", data_a_mgr, 32'h22);
    check("fwd_acc_b", data_b_mgr, 32'h22);
    tick();

    // load-use, LOAD_LAT=3
    do_reset();
    instr_exe = LW_X7; instr_de = ADD_X1_X0_X7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lu_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    instr_exe = NOP; instr_acc = LW_X7; dmem_out_acc = 32'hDEAD;
    #1;
    check("lu_done", {31'd0, stall}, 32'd0);
    check("lu_scnt", {16'd0, stall_count}, 32'd3);
    check("lu_fwd_b", data_b_mgr, 32'hDEAD);
    tick();

    // signed vs unsigned compare, flush length
    do_reset();
    instr_exe = BLTU; exe_a = 32'hFFFF_FFFF; exe_b = 32'd1;
    #1;
    check("bltu_pc", {31'd0, pc_sel}, 32'd0);
    tick();
    instr_exe = BLT;
    #1;
    check("blt_pc", {31'd0, pc_sel}, 32'd1);
    check("blt_fp0", {31'd0, false_path}, 32'd1);
    tick();
    instr_exe = NOP;
    #1;
    check("blt_pc1", {31'd0, pc_sel}, 32'd0);
    check("blt_fp1", {31'd0, false_path}, 32'd1);
    tick();
    #1;
    check("blt_fp2", {31'd0, false_path}, 32'd0);
    check("blt_fcnt", {16'd0, flush_count}, 32'd1);
    tick();

    // jump abandons a stall; branch during flush ignored
    do_reset();
    instr_exe = LW_X7; instr_de = ADD_X1_X0_X7;
    tick();
    instr_exe = JAL_X1;
    #1;
    check("jal_stall", {31'd0, stall}, 32'd0);
    check("jal_pc", {31'd0, pc_sel}, 32'd1);
    check("jal_scnt", {16'd0, stall_count}, 32'd1);
    tick();
    instr_exe = BEQ; exe_a = 32'd5; exe_b = 32'd5;
    #1;
    check("flush_br_pc", {31'd0, pc_sel}, 32'd0);
    check("flush_br_fp", {31'd0, false_path}, 32'd1);
    check("flush_br_st", {31'd0, stall}, 32'd0);
    tick();
    set_nop();
    repeat (3) tick();

    // reset inside a LOAD_LAT=4 stall
    do_reset();
    instr_exe = LW_X7; instr_de = ADD_X1_X0_X7;
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_st", {31'd0, stall2}, 32'd1);
    tick();
    rst = 1'b0; instr_exe = NOP;
    #1;
    check("rst2_stall", {31'd0, stall2}, 32'd0);
    check("rst2_scnt", {28'd0, stall_count2}, 32'd0);
    check("rst2_fcnt", {28'd0, flush_count2}, 32'd0);
    tick();

    // x0 never forwards
    set_nop();
    instr_de = ADD_X1_X0_X3; instr_exe = ADD_X0; instr_acc = ADD_X0; instr_wb = ADD_X0;
    data_a_de = 32'hA5A5_0001;
    #1;
    check("x0_ha", {31'd0, hazard_a}, 32'd0);
    check("x0_data", data_a_mgr, 32'hA5A5_0001);
    tick();

    // 4-bit counter saturation
    do_reset();
    instr_exe = LW_X7; instr_de = ADD_X1_X0_X7;
    repeat (20) tick();
    #1;
    check("sat_cnt2", {28'd0, stall_count2}, 32'd15);
    check("sat_cnt", {16'd0, stall_count}, 32'd20);
    set_nop();
    tick();

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
